// File: rtl/fetch_sequencer.sv
// Drives the fetch unit through idle/launch/run/halted, decoding branch/halt and resolving targets via a LUT.
// Latency: Start/FetchReset/Done/Timeout registered (one edge); branch outputs combinational from Instr in RUN.
// Backpressure: none; the fetch unit consumes every output each cycle, Go is a level request.
module fetch_sequencer #(
    parameter int          PC_W       = 10,
    parameter int          INSTR_W    = 9,
    parameter int          LUT_DEPTH  = 32,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
    localparam int         IDX_W      = $clog2(LUT_DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Go,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [PC_W-1:0]    ProgCtr,
    input  logic               LutWe,
    input  logic [IDX_W-1:0]   LutAddr,
    input  logic [PC_W-1:0]    LutData,
    output logic               Start,
    output logic               FetchReset,
    output logic               BranchAbs,
    output logic               BranchRelEn,
    output logic [PC_W-1:0]    Target,
    output logic               Done,
    output logic               Timeout,
    output logic [15:0]        CycleCnt,
    output logic [PC_W-1:0]    Halted_pc
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HALTED} state_t;

    state_t          state;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic [2:0]      opcode;
    logic            is_br;
    logic            is_halt;
    logic [IDX_W-1:0] idx;

    assign opcode  = Instr[INSTR_W-1 -: 3];
    assign is_br   = (opcode == 3'b111);
    assign is_halt = (opcode == 3'b110);
    assign idx     = Instr[IDX_W-1:0];

    // Target storage is deliberately not reset; it is only writable while idle.
    always_ff @(posedge Clk) begin
        if (state == IDLE && LutWe)
            lut[LutAddr] <= LutData;
    end

    always_comb begin
        BranchAbs   = 1'b0;
        BranchRelEn = 1'b0;
        Target      = '0;
        if (state == RUN && is_br) begin
            BranchAbs   = ~Instr[IDX_W];
            BranchRelEn = Instr[IDX_W];
            Target      = lut[idx];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Start      <= 1'b1;
            FetchReset <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            CycleCnt   <= '0;
            Halted_pc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Go) begin
                        state      <= LAUNCH;
                        Start      <= 1'b1;
                        FetchReset <= 1'b1;
                        Done       <= 1'b0;
                        Timeout    <= 1'b0;
                        CycleCnt   <= '0;
                    end
                end
                LAUNCH: begin
                    state      <= RUN;
                    Start      <= 1'b0;
                    FetchReset <= 1'b0;
                end
                RUN: begin
                    if (CycleCnt != 16'hFFFF)
                        CycleCnt <= CycleCnt + 16'd1;
                    // An explicit HALT on the watchdog edge is a clean finish, not a timeout.
                    if (is_halt || CycleCnt == MAX_CYCLES - 16'd1) begin
                        state     <= HALTED;
                        Start     <= 1'b1;
                        Done      <= 1'b1;
                        Timeout   <= ~is_halt;
                        Halted_pc <= ProgCtr;
                    end
                end
                HALTED: begin
                    if (!Go)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized runs against a run-level reference model.
module tb_fetch_sequencer;
    localparam int PC_W = 10;
    localparam int MAXC = 8;

    logic             Clk = 1'b0;
    logic             Reset, Go, LutWe;
    logic [8:0]       Instr;
    logic [PC_W-1:0]  ProgCtr, LutData;
    logic [4:0]       LutAddr;
    logic             Start, FetchReset, BranchAbs, BranchRelEn, Done, Timeout;
    logic [PC_W-1:0]  Target, Halted_pc;
    logic [15:0]      CycleCnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [PC_W-1:0] lut_m [32];

    localparam logic [8:0] HALT = 9'b110_000000;

    fetch_sequencer #(.PC_W(PC_W), .INSTR_W(9), .LUT_DEPTH(32), .MAX_CYCLES(16'd8)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Instr(Instr), .ProgCtr(ProgCtr),
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .Start(Start), .FetchReset(FetchReset), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
        .Target(Target), .Done(Done), .Timeout(Timeout), .CycleCnt(CycleCnt), .Halted_pc(Halted_pc)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lut_write(input int a, input logic [PC_W-1:0] d);
        LutAddr = 5'(a);
        LutData = d;
        LutWe   = 1'b1;
        tick();
        LutWe   = 1'b0;
        lut_m[a] = d;
    endtask

    task automatic launch();
        Instr = '0;
        Go    = 1'b1;
        tick();
        Go    = 1'b0;
        tick();
    endtask

    task automatic to_idle();
        Instr = HALT;
        Go    = 1'b0;
        repeat (4) tick();
        Instr = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Go = 0; LutWe = 0; Instr = '0; ProgCtr = '0; LutAddr = '0; LutData = '0;
        #1 Reset = 1'b0;
        #2;
        n_cmp++;
        if ({Start, FetchReset, Done, Timeout, CycleCnt, Halted_pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0}) begin
            n_err++;
            $display("FAIL reset_state: got S=%b FR=%b D=%b T=%b C=%0d H=%h, want 1 0 0 0 0 000",
                     Start, FetchReset, Done, Timeout, CycleCnt, Halted_pc);
        end
        #9 Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({Start, FetchReset, Done, CycleCnt} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got S=%b FR=%b D=%b C=%0d, want 1 0 0 0",
                         i, Start, FetchReset, Done, CycleCnt);
            end
        end
    endtask

    task automatic test_launch();
        lut_write(3, 10'h011);
        lut_write(5, 10'h3FC);
        // LUT write on the same edge as IDLE -> LAUNCH
        LutAddr = 5'd7; LutData = 10'h155; LutWe = 1'b1; Go = 1'b1; Instr = '0;
        lut_m[7] = 10'h155;
        tick();
        LutWe = 1'b0; Go = 1'b0;
        n_cmp++;
        if ({FetchReset, Start, CycleCnt} !== {1'b1, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL launch_cycle: got FR=%b S=%b C=%0d, want 1 1 0", FetchReset, Start, CycleCnt);
        end
        tick();
        n_cmp++;
        if ({FetchReset, Start, CycleCnt} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL run_entry: got FR=%b S=%b C=%0d, want 0 0 0", FetchReset, Start, CycleCnt);
        end
    endtask

    task automatic test_abs_branch();
        Instr = 9'b111_0_00011; #1;
        n_cmp++;
        if ({BranchAbs, BranchRelEn, Target} !== {1'b1, 1'b0, 10'h011}) begin
            n_err++;
            $display("FAIL abs3: got A=%b R=%b T=%h, want 1 0 011", BranchAbs, BranchRelEn, Target);
        end
        Instr = 9'b001_000000; #1;
        n_cmp++;
        if ({BranchAbs, BranchRelEn, Target} !== {1'b0, 1'b0, 10'h000}) begin
            n_err++;
            $display("FAIL seq_instr: got A=%b R=%b T=%h, want 0 0 000", BranchAbs, BranchRelEn, Target);
        end
        Instr = 9'b111_0_00111; #1;
        n_cmp++;
        if (Target !== 10'h155) begin
            n_err++;
            $display("FAIL launch_edge_write: got T=%h, want 155", Target);
        end
        // A write attempted while running must be dropped
        Instr = '0; LutAddr = 5'd3; LutData = 10'h3FF; LutWe = 1'b1;
        tick();
        LutWe = 1'b0;
        Instr = 9'b111_0_00011; #1;
        n_cmp++;
        if (Target !== 10'h011) begin
            n_err++;
            $display("FAIL run_write_ignored: got T=%h, want 011", Target);
        end
    endtask

    task automatic test_rel_branch();
        Instr = 9'b111_1_00101; #1;
        n_cmp++;
        if ({BranchAbs, BranchRelEn, Target} !== {1'b0, 1'b1, 10'h3FC}) begin
            n_err++;
            $display("FAIL rel5: got A=%b R=%b T=%h, want 0 1 3fc", BranchAbs, BranchRelEn, Target);
        end
    endtask

    task automatic test_halt();
        ProgCtr = 10'h02A; Instr = HALT;
        tick();
        n_cmp++;
        if ({Done, Start, Timeout, Halted_pc, CycleCnt} !== {1'b1, 1'b1, 1'b0, 10'h02A, 16'd2}) begin
            n_err++;
            $display("FAIL halt_entry: got D=%b S=%b T=%b H=%h C=%0d, want 1 1 0 02a 2",
                     Done, Start, Timeout, Halted_pc, CycleCnt);
        end
        Instr = 9'b111_0_00011; #1;
        n_cmp++;
        if ({BranchAbs, BranchRelEn, Target} !== {1'b0, 1'b0, 10'h000}) begin
            n_err++;
            $display("FAIL halted_branch_quiet: got A=%b R=%b T=%h, want 0 0 000", BranchAbs, BranchRelEn, Target);
        end
        tick();
        n_cmp++;
        if ({Done, Start, FetchReset} !== {1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL idle_done_kept: got D=%b S=%b FR=%b, want 1 1 0", Done, Start, FetchReset);
        end
        Instr = '0; Go = 1'b1;
        tick();
        Go = 1'b0;
        n_cmp++;
        if ({Done, FetchReset} !== {1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL relaunch_clears_done: got D=%b FR=%b, want 0 1", Done, FetchReset);
        end
        to_idle();
    endtask

    task automatic test_watchdog();
        launch();
        Instr = '0;
        repeat (MAXC - 1) tick();
        n_cmp++;
        if ({Start, Done, CycleCnt} !== {1'b0, 1'b0, 16'(MAXC - 1)}) begin
            n_err++;
            $display("FAIL wd_pre: got S=%b D=%b C=%0d, want 0 0 %0d", Start, Done, CycleCnt, MAXC - 1);
        end
        ProgCtr = 10'h123;
        tick();
        n_cmp++;
        if ({Start, Done, Timeout, CycleCnt, Halted_pc} !== {1'b1, 1'b1, 1'b1, 16'(MAXC), 10'h123}) begin
            n_err++;
            $display("FAIL wd_fire: got S=%b D=%b T=%b C=%0d H=%h, want 1 1 1 %0d 123",
                     Start, Done, Timeout, CycleCnt, Halted_pc, MAXC);
        end
        Go = 1'b1; ProgCtr = 10'h000;
        tick();
        Go = 1'b0;
        tick();
        n_cmp++;
        if ({Timeout, CycleCnt, Halted_pc, Done} !== {1'b1, 16'(MAXC), 10'h123, 1'b1}) begin
            n_err++;
            $display("FAIL wd_hold: got T=%b C=%0d H=%h D=%b, want 1 %0d 123 1", Timeout, CycleCnt, Halted_pc, Done, MAXC);
        end
        // HALT landing on the watchdog edge
        launch();
        repeat (MAXC - 1) tick();
        Instr = HALT;
        tick();
        n_cmp++;
        if ({Done, Timeout, CycleCnt} !== {1'b1, 1'b0, 16'(MAXC)}) begin
            n_err++;
            $display("FAIL halt_beats_wd: got D=%b T=%b C=%0d, want 1 0 %0d", Done, Timeout, CycleCnt, MAXC);
        end
        to_idle();
    endtask

    task automatic test_async_reset();
        launch();
        repeat (3) tick();
        n_cmp++;
        if ({Start, CycleCnt} !== {1'b0, 16'd3}) begin
            n_err++;
            $display("FAIL pre_reset_run: got S=%b C=%0d, want 0 3", Start, CycleCnt);
        end
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if ({Start, CycleCnt, Done} !== {1'b1, 16'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got S=%b C=%0d D=%b, want 1 0 0", Start, CycleCnt, Done);
        end
        #2 Reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({Start, FetchReset} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got S=%b FR=%b, want 1 0", Start, FetchReset);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 32; a++) lut_write(a, 10'($urandom));
        for (int r = 0; r < 20; r++) begin
            int          cnt;
            bit          ended;
            bit          exp_to;
            logic [9:0]  exp_pc;
            repeat ($urandom_range(0, 2)) lut_write(int'($urandom_range(0, 31)), 10'($urandom));
            launch();
            cnt = 0; ended = 0; exp_to = 0; exp_pc = '0;
            for (int c = 0; c < MAXC + 2 && !ended; c++) begin
                logic [8:0] ins;
                logic [2:0] op;
                bit         e_abs, e_rel;
                logic [9:0] e_tgt;
                int         k;
                k = int'($urandom_range(0, 15));
                if (k == 0)      ins = HALT;
                else if (k < 7)  ins = {3'b111, 6'($urandom)};
                else begin
                    op  = 3'($urandom_range(0, 5));
                    ins = {op, 6'($urandom)};
                end
                Instr = ins; ProgCtr = 10'($urandom);
                #1;
                e_abs = (ins[8:6] == 3'b111) && !ins[5];
                e_rel = (ins[8:6] == 3'b111) && ins[5];
                e_tgt = (e_abs || e_rel) ? lut_m[ins[4:0]] : 10'h000;
                n_cmp++;
                if ({BranchAbs, BranchRelEn, Target} !== {e_abs, e_rel, e_tgt}) begin
                    n_err++;
                    $display("FAIL rand_branch r%0d c%0d: got A=%b R=%b T=%h, want %b %b %h",
                             r, c, BranchAbs, BranchRelEn, Target, e_abs, e_rel, e_tgt);
                end
                cnt++;
                if (ins[8:6] == 3'b110) begin ended = 1; exp_to = 0; exp_pc = ProgCtr; end
                else if (cnt == MAXC)   begin ended = 1; exp_to = 1; exp_pc = ProgCtr; end
                tick();
            end
            n_cmp++;
            if ({Done, Start, Timeout, CycleCnt, Halted_pc} !== {1'b1, 1'b1, exp_to, 16'(cnt), exp_pc}) begin
                n_err++;
                $display("FAIL rand_end r%0d: got D=%b S=%b T=%b C=%0d H=%h, want 1 1 %b %0d %h",
                         r, Done, Start, Timeout, CycleCnt, Halted_pc, exp_to, cnt, exp_pc);
            end
            Go = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_abs_branch();
        test_rel_branch();
        test_halt();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
